// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment capture path.
// Alternate glyph acceptance is controlled by SEG7_CAPTURE_ALT_GLYPH_EN (see seg7_glyph_decode).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // Active-low patterns, bit6=g .. bit0=a
  localparam seg7_t SEG7_0     = 7'b1000000;
  localparam seg7_t SEG7_1     = 7'b1111001;
  localparam seg7_t SEG7_2     = 7'b0100100;
  localparam seg7_t SEG7_3     = 7'b0110000;
  localparam seg7_t SEG7_4     = 7'b0011001;
  localparam seg7_t SEG7_5     = 7'b0010010;
  localparam seg7_t SEG7_6     = 7'b0000010;
  localparam seg7_t SEG7_7     = 7'b1111000;
  localparam seg7_t SEG7_8     = 7'b0000000;
  localparam seg7_t SEG7_9     = 7'b0010000;
  localparam seg7_t SEG7_A     = 7'b0001000;
  localparam seg7_t SEG7_B     = 7'b0000011;
  localparam seg7_t SEG7_C     = 7'b1000110;
  localparam seg7_t SEG7_D     = 7'b0100001;
  localparam seg7_t SEG7_E     = 7'b0000110;
  localparam seg7_t SEG7_F     = 7'b0001110;
  localparam seg7_t SEG7_BLANK = 7'b1111111;

  localparam seg7_t SEG7_ALT_9 = 7'b0011000;
  localparam seg7_t SEG7_ALT_7 = 7'b1011000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } cap_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment pattern to {nibble, blank, invalid} decoder.
// Define SEG7_CAPTURE_ALT_GLYPH_EN to also accept tail-less 9 and 7 with segment f lit.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    nibble  = '0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG7_0:     nibble = 4'h0;
      SEG7_1:     nibble = 4'h1;
      SEG7_2:     nibble = 4'h2;
      SEG7_3:     nibble = 4'h3;
      SEG7_4:     nibble = 4'h4;
      SEG7_5:     nibble = 4'h5;
      SEG7_6:     nibble = 4'h6;
      SEG7_7:     nibble = 4'h7;
      SEG7_8:     nibble = 4'h8;
      SEG7_9:     nibble = 4'h9;
      SEG7_A:     nibble = 4'hA;
      SEG7_B:     nibble = 4'hB;
      SEG7_C:     nibble = 4'hC;
      SEG7_D:     nibble = 4'hD;
      SEG7_E:     nibble = 4'hE;
      SEG7_F:     nibble = 4'hF;
      SEG7_BLANK: blank  = 1'b1;
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
      SEG7_ALT_9: nibble = 4'h9;
      SEG7_ALT_7: nibble = 4'h7;
`endif
      default:    invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and emits whole frames.
// Glyph set widened by SEG7_CAPTURE_ALT_GLYPH_EN (inside seg7_glyph_decode).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  glyph_err,
  output logic                  an_err
);

  logic [6:0]          seg_m, s_seg, ref_seg;
  logic [DIGITS-1:0]   an_m, s_an, ref_an;
  logic [7:0]          cnt;
  cap_state_t          state, state_d;
  logic [3:0]          zeros;
  logic                an_idle, an_one, an_multi, an_bad_seen;
  logic                changed, cnt_hit;
  logic                load, inc, clr, capture;
  logic [DIGITS-1:0]   cap_vec, captured, slot_blank, slot_err;
  logic [4*DIGITS-1:0] slot_val;
  logic                full;
  logic [3:0]          dec_nib;
  logic                dec_blank, dec_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      s_seg <= '1;
      an_m  <= '1;
      s_an  <= '1;
    end else begin
      seg_m <= seg_n;
      s_seg <= seg_m;
      an_m  <= an_n;
      s_an  <= an_m;
    end
  end

  always_comb begin
    zeros = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zeros = zeros + {3'b000, ~s_an[i]};
    end
  end

  assign an_idle  = (zeros == 4'd0);
  assign an_one   = (zeros == 4'd1);
  assign an_multi = (zeros > 4'd1);
  assign changed  = (s_an != ref_an) || (s_seg != ref_seg);
  assign cnt_hit  = ({1'b0, cnt} + 9'd1) == 9'(STABLE_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (an_multi) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (an_one) state_d = SETTLE;
        SETTLE:  if (changed) state_d = an_idle ? IDLE : SETTLE;
                 else if (cnt_hit) state_d = HOLD;
        HOLD:    if (s_an != ref_an) state_d = an_idle ? IDLE : SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load    = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    capture = 1'b0;
    if (an_multi) begin
      clr = 1'b1;
    end else begin
      case (state)
        IDLE:   if (an_one) load = 1'b1;
        SETTLE: begin
          if (changed) begin
            if (an_idle) clr  = 1'b1;
            else         load = 1'b1;
          end else if (cnt_hit) begin
            capture = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
        HOLD:   if (s_an != ref_an && !an_idle) load = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_seg <= '1;
      ref_an  <= '1;
      cnt     <= '0;
    end else if (load) begin
      ref_seg <= s_seg;
      ref_an  <= s_an;
      cnt     <= 8'd1;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

  seg7_glyph_decode u_decode (
    .pattern (ref_seg),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .invalid (dec_inv)
  );

  // The low anode bit of the reference directly selects the slot.
  assign cap_vec = ~ref_an & {DIGITS{capture}};
  assign full    = &captured;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_val   <= '0;
      slot_blank <= '0;
      slot_err   <= '0;
      captured   <= '0;
    end else begin
      captured <= (full ? '0 : captured) | cap_vec;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (cap_vec[i]) begin
          slot_val[4*i +: 4] <= dec_nib;
          slot_blank[i]      <= dec_blank;
          slot_err[i]        <= dec_inv;
        end else if (full) begin
          slot_err[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      blank       <= '0;
      glyph_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= full;
      if (full) begin
        value     <= slot_val;
        blank     <= slot_blank;
        glyph_err <= |slot_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_err      <= 1'b0;
      an_bad_seen <= 1'b0;
    end else begin
      an_err      <= an_multi && !an_bad_seen;
      an_bad_seen <= an_multi;
    end
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reads a multiplexed, active-low 7-segment display bus (segment lines plus digit-select anodes) and recovers the hex value shown on each digit. It is the inverse of the team's hex-to-segment display driver.
- Used for loopback self-test of display paths and for sniffing external display boards.
- Samples asynchronous pins, waits for each digit pattern to settle, and decodes it to 4 bits.
- Emits a full multi-digit word once every digit has been captured.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines), 1..8
- STABLE_CYC, 8, consecutive identical samples required before a digit is accepted, 2..255

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_n  input  7  segment lines, active-low (0 = lit), bit0=a .. bit6=g; asynchronous to clk
- an_n  input  DIGITS  digit selects, active-low, one-hot-low when driving; asynchronous to clk
- value  output  4*DIGITS  decoded nibbles; digit i in bits [4i+3:4i]
- blank  output  DIGITS  1 = digit i was dark (1111111) at capture
- frame_valid  output  1  one-cycle pulse: value/blank/glyph_err updated for a complete frame
- glyph_err  output  1  valid with frame_valid: at least one digit held an undecodable pattern
- an_err  output  1  one-cycle pulse when synchronised an_n has more than one low bit

Behaviour:
- Reset (async assert, sync release): all outputs 0, sync flops to all-ones, state IDLE, counter 0, captured mask 0.
- Input path: seg_n and an_n pass through 2-flop synchronisers. All logic below uses the synchronised values (s_seg, s_an).
- Decode table (s_seg to nibble), active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 = blank; nibble stored as 0, blank bit set.
  - Any other pattern = invalid; nibble stored as 0, per-digit err bit set.
- FSM states:
  - IDLE: s_an all-ones. When s_an is one-hot-low → SETTLE, load ref_seg=s_seg, ref_an=s_an, cnt=1.
  - SETTLE: if s_an!=ref_an or s_seg!=ref_seg → reload ref from current inputs, cnt=1; go to IDLE if s_an is all-ones. Otherwise cnt++.
  - SETTLE accept: when cnt reaches STABLE_CYC, latch the decode into slot idx = position of the low bit, set captured[idx] → HOLD.
  - HOLD: stay while s_an==ref_an. On change → IDLE if all-ones, else SETTLE with reload. A digit is never recaptured within one selection.
- Invalid anode (more than one bit low): an_err pulses on the first cycle of detection. FSM → IDLE, cnt cleared, no capture. The pulse repeats only after a valid or all-ones pattern has intervened.
- Frame completion: in the cycle after captured becomes all-ones:
  - value and blank are updated from the slot registers;
  - glyph_err = OR of the per-slot err bits;
  - frame_valid pulses for 1 cycle;
  - captured and the err bits clear.
  - Captures made in that same cycle land in the next frame.
- Latency: pin change to slot latch = 2 (sync) + STABLE_CYC cycles. Last slot latch to frame_valid = 1 cycle.
- Recapture of an already-captured slot in the same frame overwrites it; captured is unchanged.
- Between frames, value, blank and glyph_err hold their last values.
- Reset mid-frame discards partial slots.

Optional Feature:
- SEG7_CAPTURE_ALT_GLYPH_EN defined: the decoder also accepts the alternate glyphs:
  - tail-less 9 = 0011000 → 9
  - 7 with segment f lit = 1011000 → 7
  - 6 without top = 0000011 stays b (unchanged, no ambiguity added)
- Undefined: the alternate glyphs are invalid and set glyph_err.

Decomposition:
- Shared package seg7_pkg:
  - seg7_t (7-bit active-low pattern) typedef
  - the 16 glyph constants plus SEG7_BLANK
  - capture FSM state enum {IDLE, SETTLE, HOLD}
- One sub-module: seg7_glyph_decode, a pure combinational pattern → {nibble, blank, invalid} decoder, reusable for display checkers.
- Synchronisers use the team's standard 2-flop cell.

Test Plan:
- Reset, then scan digits 0..3 with patterns for 1,2,3,4 (0x4321 with digit0=1), each held 20 cycles, STABLE_CYC=8 → one frame_valid pulse, value=16'h4321, blank=0, glyph_err=0.
- Glitchy settle: digit0 toggles 0010010/0000010 every 3 cycles for 30 cycles, then settles on 0000010 → slot0=6; no capture of 5 before settle.
- Invalid glyph 1010101 on digit2, others valid → frame_valid with glyph_err=1, value[11:8]=0. Same test with 1111111 → blank[2]=1, glyph_err=0.
- an_n=4'b0101 for 10 cycles mid-scan → a single an_err pulse, no capture, FSM returns to IDLE. The following valid scan completes normally.
- Assert rst_n low asynchronously after 3 of 4 digits captured → all outputs 0 immediately. The next full scan yields exactly one frame_valid.
- Pattern 0011000 on digit1: with SEG7_CAPTURE_ALT_GLYPH_EN → nibble 9, glyph_err=0. Without it → glyph_err=1.
